// File: rtl/tlc5620_pkg.sv
// Shared definitions for the TLC5620 channel scheduler: channel codes, frame
// layout, FSM state type and the level-estimate helper.
package tlc5620_pkg;

  typedef enum logic [1:0] {
    DAC_A = 2'd0,
    DAC_B = 2'd1,
    DAC_C = 2'd2,
    DAC_D = 2'd3
  } dac_ch_e;

  localparam int unsigned FRAME_W       = 11;
  localparam int unsigned FRAME_CH_HI   = 10;
  localparam int unsigned FRAME_CH_LO   = 9;
  localparam int unsigned FRAME_RNG_BIT = 8;
  localparam int unsigned FRAME_CODE_HI = 7;
  localparam int unsigned FRAME_CODE_LO = 0;
  localparam int unsigned EST_W         = 6;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PRESENT = 2'd1,
    ST_LDAC    = 2'd2
  } state_e;

  function automatic logic [FRAME_W-1:0] pack_frame(input logic [1:0] ch,
                                                    input logic       rng,
                                                    input logic [7:0] code);
    return {ch, rng, code};
  endfunction

  // 25*(rng+1)*code peaks at 12750, so 14 bits hold the product exactly.
  function automatic logic [EST_W-1:0] est_level_f(input logic       rng,
                                                   input logic [7:0] code);
    logic [13:0] prod;
    prod = 14'd25 * ({13'd0, rng} + 14'd1) * {6'd0, code};
    return prod[13:8];
  endfunction

endpackage

// File: rtl/rr_arb4.sv
// Four-way round-robin selector; the search starts just after the last
// granted index, which only moves when the grant is taken (adv).
module rr_arb4
  import tlc5620_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic       adv,
  output logic       gnt_vld,
  output logic [1:0] gnt_idx
);

  logic [1:0] last_q;
  logic [1:0] last_d;
  logic [1:0] cand;

  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = last_q;
    cand    = '0;
    for (int unsigned k = 1; k <= 4; k++) begin
      cand = last_q + 2'(k);
      if (!gnt_vld && req[cand]) begin
        gnt_vld = 1'b1;
        gnt_idx = cand;
      end
    end
    last_d = (adv && gnt_vld) ? gnt_idx : last_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_q <= DAC_D;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/tlc5620_ch_sched.sv
// TLC5620 channel scheduler: per-channel shadow registers, round-robin frame
// issue to a serializer, LDAC pulse generation and a per-frame level estimate.
module tlc5620_ch_sched
  import tlc5620_pkg::*;
#(
  parameter int unsigned UPDATE_MODE = 0,
  parameter int unsigned LDAC_WIDTH  = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_en,
  input  logic [1:0]         wr_ch,
  input  logic               wr_rng,
  input  logic [7:0]         wr_code,
  input  logic               commit,
  output logic               frame_valid,
  output logic [FRAME_W-1:0] frame_data,
  input  logic               frame_ready,
  output logic               ldac_req,
  output logic [EST_W-1:0]   est_level,
  output logic               idle
);

  state_e             state_q, state_d;
  logic [3:0]         dirty_q, dirty_d;
  logic [3:0]         rng_q, rng_d;
  logic [3:0][7:0]    code_q, code_d;
  logic               pend_q, pend_d;
  logic [3:0]         cnt_q, cnt_d;
  logic               frame_valid_q, frame_valid_d;
  logic [FRAME_W-1:0] frame_data_q, frame_data_d;
  logic               ldac_req_q, ldac_req_d;
  logic [EST_W-1:0]   est_level_q, est_level_d;

  logic               arb_vld;
  logic [1:0]         arb_idx;
  logic               arb_adv;
  logic               hs;
  logic               enter_ldac;

  rr_arb4 u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (dirty_q),
    .adv     (arb_adv),
    .gnt_vld (arb_vld),
    .gnt_idx (arb_idx)
  );

  assign hs = frame_valid_q && frame_ready;

  always_comb begin
    state_d       = state_q;
    dirty_d       = dirty_q;
    rng_d         = rng_q;
    code_d        = code_q;
    cnt_d         = cnt_q;
    frame_valid_d = frame_valid_q;
    frame_data_d  = frame_data_q;
    ldac_req_d    = ldac_req_q;
    est_level_d   = est_level_q;
    arb_adv       = 1'b0;
    enter_ldac    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (arb_vld) begin
          arb_adv          = 1'b1;
          frame_data_d     = pack_frame(arb_idx, rng_q[arb_idx], code_q[arb_idx]);
          dirty_d[arb_idx] = 1'b0;
          frame_valid_d    = 1'b1;
          state_d          = ST_PRESENT;
        end else if (UPDATE_MODE != 0 && pend_q) begin
          enter_ldac = 1'b1;
        end
      end
      ST_PRESENT: begin
        if (hs) begin
          est_level_d   = est_level_f(frame_data_q[FRAME_RNG_BIT],
                                      frame_data_q[FRAME_CODE_HI:FRAME_CODE_LO]);
          frame_valid_d = 1'b0;
          if (UPDATE_MODE == 0 || (pend_q && dirty_q == '0)) begin
            enter_ldac = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_LDAC: begin
        if (cnt_q == '0) begin
          ldac_req_d = 1'b0;
          state_d    = ST_IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (enter_ldac) begin
      state_d    = ST_LDAC;
      ldac_req_d = 1'b1;
      cnt_d      = 4'(LDAC_WIDTH - 1);
    end

    // A commit in the cycle LDAC is entered survives the clear.
    pend_d = (UPDATE_MODE != 0) && ((pend_q && !enter_ldac) || commit);

    // Applied last so a write beats the dirty-clear of the channel being issued.
    if (wr_en) begin
      rng_d[wr_ch]   = wr_rng;
      code_d[wr_ch]  = wr_code;
      dirty_d[wr_ch] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      dirty_q       <= '0;
      rng_q         <= '0;
      code_q        <= '0;
      pend_q        <= 1'b0;
      cnt_q         <= '0;
      frame_valid_q <= 1'b0;
      frame_data_q  <= '0;
      ldac_req_q    <= 1'b0;
      est_level_q   <= '0;
    end else begin
      state_q       <= state_d;
      dirty_q       <= dirty_d;
      rng_q         <= rng_d;
      code_q        <= code_d;
      pend_q        <= pend_d;
      cnt_q         <= cnt_d;
      frame_valid_q <= frame_valid_d;
      frame_data_q  <= frame_data_d;
      ldac_req_q    <= ldac_req_d;
      est_level_q   <= est_level_d;
    end
  end

  assign frame_valid = frame_valid_q;
  assign frame_data  = frame_data_q;
  assign ldac_req    = ldac_req_q;
  assign est_level   = est_level_q;
  assign idle        = (state_q == ST_IDLE) && (dirty_q == '0) && !pend_q;

endmodule

// File: tb/tb_tlc5620_ch_sched.sv
// Bench for tlc5620_ch_sched: one instance per update mode sharing stimulus,
// directed vectors for the corner cases and a randomized scoreboard phase.
module tb_tlc5620_ch_sched;

  logic        clk;
  logic        rst;
  logic        wr_en;
  logic [1:0]  wr_ch;
  logic        wr_rng;
  logic [7:0]  wr_code;
  logic        commit;
  logic        frame_ready;

  logic        fv0, fv1, ld0, ld1, idle0, idle1;
  logic [10:0] fd0, fd1;
  logic [5:0]  est0, est1;

  int n_checks = 0;
  int n_fail   = 0;

  tlc5620_ch_sched #(.UPDATE_MODE(0), .LDAC_WIDTH(2)) dut0 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_ch(wr_ch), .wr_rng(wr_rng),
    .wr_code(wr_code), .commit(commit), .frame_valid(fv0), .frame_data(fd0),
    .frame_ready(frame_ready), .ldac_req(ld0), .est_level(est0), .idle(idle0)
  );

  tlc5620_ch_sched #(.UPDATE_MODE(1), .LDAC_WIDTH(3)) dut1 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_ch(wr_ch), .wr_rng(wr_rng),
    .wr_code(wr_code), .commit(commit), .frame_valid(fv1), .frame_data(fd1),
    .frame_ready(frame_ready), .ldac_req(ld1), .est_level(est1), .idle(idle1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", nm, act, exp);
    end
  endtask

  task automatic write(input logic [1:0] ch, input logic r, input logic [7:0] c);
    wr_en   = 1'b1;
    wr_ch   = ch;
    wr_rng  = r;
    wr_code = c;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    wr_en  = 1'b0;
    commit = 1'b0;
    while (!(idle0 && idle1) && n < 40) begin
      tick();
      n++;
    end
    chk("wait_idle", {30'd0, idle0, idle1}, 32'd3);
  endtask

  task automatic next_hs0(output logic [10:0] fd, output bit ok);
    ok = 1'b0;
    fd = '0;
    for (int i = 0; i < 40 && !ok; i++) begin
      if (fv0 && frame_ready) begin
        fd = fd0;
        ok = 1'b1;
      end
      tick();
    end
  endtask

  // Level estimate straight from the definition, in plain integer arithmetic.
  function automatic int ref_est(input logic [10:0] f);
    int mult;
    int code;
    mult = f[8] ? 2 : 1;
    code = int'(f[7:0]);
    return (25 * mult * code) / 256;
  endfunction

  // ---------------- scoreboard model for the randomized phase ----------------
  bit          model_on = 1'b0;
  bit   [3:0]  m_dirty  [2];
  logic [8:0]  m_shadow [2][4];
  int          m_last   [2];
  bit          m_pv     [2];
  logic [10:0] m_exp    [2];
  bit          est_due  [2];
  int          est_exp  [2];
  int          m_run    [2];
  bit          m_pw;
  logic [1:0]  m_pch;
  logic [8:0]  m_pval;

  always @(negedge clk) begin
    if (model_on) begin
      for (int d = 0; d < 2; d++) begin
        logic        v, ld, idl;
        logic [10:0] fd;
        logic [5:0]  es;
        int          c;
        bit          found;
        v   = (d == 0) ? fv0 : fv1;
        ld  = (d == 0) ? ld0 : ld1;
        idl = (d == 0) ? idle0 : idle1;
        fd  = (d == 0) ? fd0 : fd1;
        es  = (d == 0) ? est0 : est1;
        if (est_due[d]) begin
          chk("model_est", {26'd0, es}, est_exp[d]);
          est_due[d] = 1'b0;
        end
        if (v && !m_pv[d]) begin
          found = 1'b0;
          for (int k = 1; k <= 4; k++) begin
            c = (m_last[d] + k) % 4;
            if (!found && m_dirty[d][c]) begin
              found     = 1'b1;
              m_last[d] = c;
            end
          end
          chk("model_frame_src", {31'd0, found}, 32'd1);
          if (found) begin
            m_dirty[d][m_last[d]] = 1'b0;
            m_exp[d] = {2'(m_last[d]), m_shadow[d][m_last[d]]};
          end
        end
        if (v) chk("model_frame_data", {21'd0, fd}, {21'd0, m_exp[d]});
        if (v && frame_ready) begin
          est_exp[d] = ref_est(m_exp[d]);
          est_due[d] = 1'b1;
        end
        if (ld) begin
          m_run[d]++;
        end else if (m_run[d] > 0) begin
          chk("model_ldac_width", m_run[d], (d == 0) ? 2 : 3);
          m_run[d] = 0;
        end
        if (m_pw) begin
          m_shadow[d][m_pch] = m_pval;
          m_dirty[d][m_pch]  = 1'b1;
        end
        if (d == 0) chk("model_idle", {31'd0, idl}, {31'd0, (m_dirty[0] == 4'd0) && !v && !ld});
        m_pv[d] = v;
      end
      m_pw   = wr_en;
      m_pch  = wr_ch;
      m_pval = {wr_rng, wr_code};
    end
  end

  // ---------------- directed and randomized stimulus ----------------
  typedef struct {
    logic [1:0]  ch;
    logic        rng;
    logic [7:0]  code;
    logic [10:0] frame;
    logic [5:0]  est;
  } vec_t;

  vec_t tbl [7];

  initial begin
    logic [10:0] got;
    logic [10:0] exp_rr [4];
    logic [10:0] m1_fd  [3];
    bit          ok;
    int          hs_cnt, h3, l1, ld_total, early;

    tbl[0] = '{2'd1, 1'b0, 8'h80, 11'h280, 6'd12};
    tbl[1] = '{2'd0, 1'b1, 8'hFF, 11'h1FF, 6'd49};
    tbl[2] = '{2'd2, 1'b1, 8'h80, 11'h580, 6'd25};
    tbl[3] = '{2'd3, 1'b0, 8'hFF, 11'h6FF, 6'd24};
    tbl[4] = '{2'd0, 1'b0, 8'h00, 11'h000, 6'd0};
    tbl[5] = '{2'd1, 1'b1, 8'h0A, 11'h30A, 6'd1};
    tbl[6] = '{2'd3, 1'b1, 8'h34, 11'h734, 6'd10};

    rst = 1'b1; wr_en = 1'b0; wr_ch = '0; wr_rng = 1'b0; wr_code = '0;
    commit = 1'b0; frame_ready = 1'b1;
    tick(); tick();

    // write during reset must be dropped
    write(2'd1, 1'b0, 8'h12);
    tick();
    rst = 1'b0; wr_en = 1'b0;
    chk("rst_valid", {31'd0, fv0}, 32'd0);
    chk("rst_data", {21'd0, fd0}, 32'd0);
    chk("rst_ldac", {31'd0, ld0}, 32'd0);
    chk("rst_est", {26'd0, est0}, 32'd0);
    chk("rst_idle0", {31'd0, idle0}, 32'd1);
    chk("rst_idle1", {31'd0, idle1}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      chk("rst_write_dropped", {30'd0, fv0, fv1}, 32'd0);
      tick();
    end

    // table: latency, frame packing, estimate, LDAC width (mode 0)
    for (int i = 0; i < 7; i++) begin
      wait_idle();
      write(tbl[i].ch, tbl[i].rng, tbl[i].code);
      tick();
      wr_en = 1'b0;
      chk("tbl_valid_n1", {31'd0, fv0}, 32'd0);
      tick();
      chk("tbl_valid_n2", {31'd0, fv0}, 32'd1);
      chk("tbl_frame", {21'd0, fd0}, {21'd0, tbl[i].frame});
      tick();
      chk("tbl_est", {26'd0, est0}, {26'd0, tbl[i].est});
      chk("tbl_ldac_1", {31'd0, ld0}, 32'd1);
      chk("tbl_valid_off", {31'd0, fv0}, 32'd0);
      tick();
      chk("tbl_ldac_2", {31'd0, ld0}, 32'd1);
      tick();
      chk("tbl_ldac_end", {31'd0, ld0}, 32'd0);
      chk("tbl_idle", {31'd0, idle0}, 32'd1);
    end

    // round robin: D stalled, then D (same-edge rewrite), A, C -> A, C, D
    wait_idle();
    frame_ready = 1'b0;
    write(2'd3, 1'b0, 8'h11); tick();
    write(2'd3, 1'b0, 8'h22); tick();
    chk("rr_stall_valid", {31'd0, fv0}, 32'd1);
    write(2'd0, 1'b0, 8'h33); tick();
    write(2'd2, 1'b0, 8'h44); tick();
    wr_en = 1'b0;
    chk("rr_stall_frame", {21'd0, fd0}, 32'h611);
    frame_ready = 1'b1;
    exp_rr[0] = 11'h611; exp_rr[1] = 11'h033; exp_rr[2] = 11'h444; exp_rr[3] = 11'h622;
    for (int k = 0; k < 4; k++) begin
      next_hs0(got, ok);
      chk("rr_hs_seen", {31'd0, ok}, 32'd1);
      chk("rr_order", {21'd0, got}, {21'd0, exp_rr[k]});
    end

    // backpressure with a rewrite of the in-flight channel
    wait_idle();
    frame_ready = 1'b0;
    write(2'd0, 1'b0, 8'h10); tick();
    wr_en = 1'b0; tick();
    for (int i = 0; i < 10; i++) begin
      chk("bp_valid", {31'd0, fv0}, 32'd1);
      chk("bp_stable", {21'd0, fd0}, 32'h010);
      if (i == 3) write(2'd0, 1'b0, 8'hFF);
      else wr_en = 1'b0;
      tick();
    end
    wr_en = 1'b0;
    frame_ready = 1'b1;
    next_hs0(got, ok);
    chk("bp_hs1_seen", {31'd0, ok}, 32'd1);
    chk("bp_first_old", {21'd0, got}, 32'h010);
    chk("bp_est1", {26'd0, est0}, 32'd1);
    next_hs0(got, ok);
    chk("bp_hs2_seen", {31'd0, ok}, 32'd1);
    chk("bp_second_new", {21'd0, got}, 32'h0FF);
    chk("bp_est2", {26'd0, est0}, 32'd24);

    // reset while a frame is being offered
    wait_idle();
    frame_ready = 1'b0;
    write(2'd1, 1'b0, 8'h55); tick();
    wr_en = 1'b0; tick();
    chk("rstp_presenting", {31'd0, fv0}, 32'd1);
    rst = 1'b1; tick();
    chk("rstp_valid_drop", {30'd0, fv0, fv1}, 32'd0);
    chk("rstp_idle", {30'd0, idle0, idle1}, 32'd3);
    rst = 1'b0;
    frame_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      chk("rstp_no_reoffer", {30'd0, fv0, fv1}, 32'd0);
      tick();
    end

    // mode 1: three frames, one LDAC burst after the third handshake
    wait_idle();
    frame_ready = 1'b1;
    hs_cnt = 0; h3 = -1; l1 = -1; ld_total = 0; early = 0;
    for (int i = 0; i < 40; i++) begin
      wr_en = 1'b0; commit = 1'b0;
      case (i)
        0: write(2'd0, 1'b0, 8'h01);
        1: write(2'd1, 1'b0, 8'h02);
        2: write(2'd2, 1'b0, 8'h03);
        3: commit = 1'b1;
        default: ;
      endcase
      if (fv1 && frame_ready) begin
        if (hs_cnt < 3) m1_fd[hs_cnt] = fd1;
        hs_cnt++;
        if (hs_cnt == 3) h3 = i;
      end
      if (ld1) begin
        if (hs_cnt < 3) early++;
        if (l1 < 0) l1 = i;
        ld_total++;
      end
      tick();
    end
    wr_en = 1'b0; commit = 1'b0;
    chk("m1_hs_count", hs_cnt, 32'd3);
    chk("m1_frame_a", {21'd0, m1_fd[0]}, 32'h001);
    chk("m1_frame_b", {21'd0, m1_fd[1]}, 32'h202);
    chk("m1_frame_c", {21'd0, m1_fd[2]}, 32'h403);
    chk("m1_no_early_ldac", early, 32'd0);
    chk("m1_ldac_start", l1, h3 + 1);
    chk("m1_ldac_total", ld_total, 32'd3);

    // bare commit, re-commit in the entry cycle; mode 0 ignores both
    wait_idle();
    for (int i = 0; i < 12; i++) begin
      commit = (i < 2);
      chk("cm_ldac1", {31'd0, ld1}, {31'd0, (i >= 2 && i <= 4) || (i >= 6 && i <= 8)});
      chk("cm_idle1", {31'd0, idle1}, {31'd0, (i == 0) || (i >= 9)});
      chk("cm_ldac0", {31'd0, ld0}, 32'd0);
      chk("cm_idle0", {31'd0, idle0}, 32'd1);
      tick();
    end
    commit = 1'b0;

    // randomized phase against the scoreboard model
    rst = 1'b1; tick(); tick();
    rst = 1'b0;
    for (int d = 0; d < 2; d++) begin
      m_dirty[d] = '0; m_last[d] = 3; m_pv[d] = 1'b0; m_exp[d] = '0;
      est_due[d] = 1'b0; est_exp[d] = 0; m_run[d] = 0;
      for (int c = 0; c < 4; c++) m_shadow[d][c] = '0;
    end
    m_pw = 1'b0; m_pch = '0; m_pval = '0;
    model_on = 1'b1;
    for (int i = 0; i < 600; i++) begin
      wr_en       = ($urandom_range(0, 99) < 35);
      wr_ch       = 2'($urandom_range(0, 3));
      wr_rng      = 1'($urandom_range(0, 1));
      wr_code     = 8'($urandom_range(0, 255));
      frame_ready = ($urandom_range(0, 99) < 65);
      commit      = ($urandom_range(0, 99) < 4);
      tick();
    end
    wr_en = 1'b0; commit = 1'b0; frame_ready = 1'b1;
    for (int i = 0; i < 60; i++) tick();
    @(negedge clk);
    model_on = 1'b0;
    chk("drain_model_dirty0", {28'd0, m_dirty[0]}, 32'd0);
    chk("drain_model_dirty1", {28'd0, m_dirty[1]}, 32'd0);
    chk("drain_idle", {30'd0, idle0, idle1}, 32'd3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
